// File: rtl/instr_stream_encoder.sv
`default_nettype none
// ==== instr_stream_encoder: RV32I field-to-word encoder with flow control, fill counter, sticky error ====
// ==== Rev 1.0 -- optional immediate range checking via RVENC_IMM_CHECK_EN                              ====
module instr_stream_encoder #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_class,
  input  logic [2:0]            in_funct3,
  input  logic                  in_alt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [DEPTH_LOG2-1:0] out_addr,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  err,
  output logic                  err_pulse
);

  localparam logic [DEPTH_LOG2:0] C_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  localparam logic [3:0] C_CLS_R     = 4'd0;
  localparam logic [3:0] C_CLS_OPIMM = 4'd1;
  localparam logic [3:0] C_CLS_LOAD  = 4'd2;
  localparam logic [3:0] C_CLS_STORE = 4'd3;
  localparam logic [3:0] C_CLS_BR    = 4'd4;
  localparam logic [3:0] C_CLS_JALR  = 4'd5;
  localparam logic [3:0] C_CLS_LUI   = 4'd6;
  localparam logic [3:0] C_CLS_AUIPC = 4'd7;
  localparam logic [3:0] C_CLS_JAL   = 4'd8;

  localparam logic [6:0] C_OP_R     = 7'b0110011;
  localparam logic [6:0] C_OP_OPIMM = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OP_STORE = 7'b0100011;
  localparam logic [6:0] C_OP_BR    = 7'b1100011;
  localparam logic [6:0] C_OP_JALR  = 7'b1100111;
  localparam logic [6:0] C_OP_LUI   = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC = 7'b0010111;
  localparam logic [6:0] C_OP_JAL   = 7'b1101111;

  logic                r_out_valid;
  logic [31:0]         r_out_instr;
  logic [DEPTH_LOG2-1:0] r_out_addr;
  logic [DEPTH_LOG2:0] r_count;
  logic                r_err;
  logic                r_err_pulse;

  logic [31:0] w_word;
  logic        w_legal;
  logic        w_full;
  logic        w_accept;
  logic        w_shift;
  logic [6:0]  w_funct7;
  logic        w_fit_i, w_fit_b, w_fit_j, w_fit_sh, w_fit_u;

`ifdef RVENC_IMM_CHECK_EN
  // Range checks: upper bits must be a pure sign extension of the encodable field.
  assign w_fit_i  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign w_fit_b  = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign w_fit_j  = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
  assign w_fit_sh = ~(|in_imm[31:5]);
  assign w_fit_u  = ~(|in_imm[11:0]);
`else
  assign w_fit_i  = 1'b1;
  assign w_fit_b  = 1'b1;
  assign w_fit_j  = 1'b1;
  assign w_fit_sh = 1'b1;
  assign w_fit_u  = 1'b1;
`endif

  assign w_shift  = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  assign w_funct7 = in_alt ? 7'b0100000 : 7'b0000000;

  always_comb begin
    w_word  = 32'd0;
    w_legal = 1'b0;
    case (in_class)
      C_CLS_R: begin
        w_legal = !in_alt || (in_funct3 == 3'b000) || (in_funct3 == 3'b101);
        w_word  = {w_funct7, in_rs2, in_rs1, in_funct3, in_rd, C_OP_R};
      end
      C_CLS_OPIMM: begin
        if (w_shift) begin
          w_legal = (!in_alt || (in_funct3 == 3'b101)) && w_fit_sh;
          w_word  = {w_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, C_OP_OPIMM};
        end else begin
          w_legal = !in_alt && w_fit_i;
          w_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, C_OP_OPIMM};
        end
      end
      C_CLS_LOAD: begin
        w_legal = (in_funct3 != 3'd3) && (in_funct3 != 3'd6) && (in_funct3 != 3'd7) && w_fit_i;
        w_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, C_OP_LOAD};
      end
      C_CLS_STORE: begin
        w_legal = (in_funct3 <= 3'd2) && w_fit_i;
        w_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], C_OP_STORE};
      end
      C_CLS_BR: begin
        w_legal = (in_funct3 != 3'd2) && (in_funct3 != 3'd3) && w_fit_b;
        w_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], C_OP_BR};
      end
      C_CLS_JALR: begin
        w_legal = w_fit_i;
        w_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, C_OP_JALR};
      end
      C_CLS_LUI: begin
        w_legal = w_fit_u;
        w_word  = {in_imm[31:12], in_rd, C_OP_LUI};
      end
      C_CLS_AUIPC: begin
        w_legal = w_fit_u;
        w_word  = {in_imm[31:12], in_rd, C_OP_AUIPC};
      end
      C_CLS_JAL: begin
        w_legal = w_fit_j;
        w_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, C_OP_JAL};
      end
      default: begin
        w_word  = 32'd0;
        w_legal = 1'b0;
      end
    endcase
  end

  assign w_full   = (r_count == C_DEPTH);
  assign in_ready = !w_full && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Count never exceeds the depth because in_ready drops at full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_instr <= 32'd0;
      r_out_addr  <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_err_pulse <= 1'b0;
    end else if (clr) begin
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= w_accept && !w_legal;
      if (w_accept && !w_legal) begin
        r_err <= 1'b1;
      end
      if (w_accept && w_legal) begin
        r_out_instr <= w_word;
        r_out_addr  <= r_count[DEPTH_LOG2-1:0];
        r_out_valid <= 1'b1;
        r_count     <= r_count + 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_addr  = r_out_addr;
  assign count     = r_count;
  assign full      = w_full;
  assign err       = r_err;
  assign err_pulse = r_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_instr_stream_encoder.sv
`default_nettype none
// Testbench for instr_stream_encoder: directed vectors plus randomized stream against a field-level reference model.
module tb_instr_stream_encoder;

  localparam int D   = 2;
  localparam int CAP = 1 << D;

  logic          clk = 1'b0;
  logic          rst, clr, in_valid, in_ready, in_alt, out_valid, out_ready;
  logic [3:0]    in_class;
  logic [2:0]    in_funct3;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm, out_instr;
  logic [D-1:0]  out_addr;
  logic [D:0]    count;
  logic          full, err, err_pulse;

  always #5 clk = ~clk;

  instr_stream_encoder #(.DEPTH_LOG2(D)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_alt(in_alt),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .count(count), .full(full), .err(err), .err_pulse(err_pulse)
  );

  int checks = 0;
  int errors = 0;

  // Reference state, expressed as plain counters and flags.
  bit          m_valid = 0, m_err = 0, m_pulse = 0;
  logic [31:0] m_instr = 32'd0;
  int          m_addr = 0, m_count = 0;
  bit          exp_rdy, seen_ready;

  function automatic logic [32:0] ref_encode(input int cls, input int f3, input int alt,
                                             input int rd, input int rs1, input int rs2,
                                             input logic [31:0] imm);
    logic [31:0] w;
    bit ok, is_shift;
    int s;
    w = 32'd0;
    ok = 1;
    s = $signed(imm);
    is_shift = (cls == 1) && (f3 == 1 || f3 == 5);
    case (cls)
      0: begin w[6:0] = 7'b0110011; ok = (alt == 0) || (f3 inside {0, 5}); end
      1: begin w[6:0] = 7'b0010011; ok = (alt == 0) || (f3 == 5); end
      2: begin w[6:0] = 7'b0000011; ok = f3 inside {0, 1, 2, 4, 5}; end
      3: begin w[6:0] = 7'b0100011; ok = f3 inside {0, 1, 2}; end
      4: begin w[6:0] = 7'b1100011; ok = f3 inside {0, 1, 4, 5, 6, 7}; end
      5: w[6:0] = 7'b1100111;
      6: w[6:0] = 7'b0110111;
      7: w[6:0] = 7'b0010111;
      8: w[6:0] = 7'b1101111;
      default: ok = 0;
    endcase
    if (cls inside {0, 1, 2, 5, 6, 7, 8}) w[11:7] = 5'(rd);
    if (cls inside {0, 1, 2, 3, 4}) w[14:12] = 3'(f3);
    if (cls inside {0, 1, 2, 3, 4, 5}) w[19:15] = 5'(rs1);
    if (cls inside {0, 3, 4}) w[24:20] = 5'(rs2);
    if (cls == 0) w[31:25] = (alt != 0) ? 7'h20 : 7'h00;
    if (is_shift) begin
      w[24:20] = imm[4:0];
      w[31:25] = (alt != 0) ? 7'h20 : 7'h00;
    end else if (cls inside {1, 2, 5}) begin
      w[31:20] = imm[11:0];
    end
    if (cls == 3) begin w[31:25] = imm[11:5]; w[11:7] = imm[4:0]; end
    if (cls == 4) begin
      w[31] = imm[12]; w[30:25] = imm[10:5]; w[11:8] = imm[4:1]; w[7] = imm[11];
    end
    if (cls inside {6, 7}) w[31:12] = imm[31:12];
    if (cls == 8) begin
      w[31] = imm[20]; w[30:21] = imm[10:1]; w[20] = imm[11]; w[19:12] = imm[19:12];
    end
`ifdef RVENC_IMM_CHECK_EN
    if (is_shift) ok = ok && s >= 0 && s <= 31;
    else if (cls inside {1, 2, 3, 5}) ok = ok && s >= -2048 && s <= 2047;
    if (cls == 4) ok = ok && s >= -4096 && s <= 4094 && (s % 2 == 0);
    if (cls == 8) ok = ok && s >= -1048576 && s <= 1048574 && (s % 2 == 0);
    if (cls inside {6, 7}) ok = ok && (imm % 4096 == 0);
`endif
    return {ok, w};
  endfunction

  // Drives one cycle of inputs, samples in_ready, then advances the model across the edge.
  task automatic tick(input int v, input int cls, input int f3, input int alt, input int rd,
                      input int rs1, input int rs2, input logic [31:0] imm,
                      input int ordy, input int c, input int r);
    logic [32:0] e;
    bit acc;
    in_valid = (v != 0); in_class = 4'(cls); in_funct3 = 3'(f3); in_alt = (alt != 0);
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
    out_ready = (ordy != 0); clr = (c != 0); rst = (r != 0);
    exp_rdy = (m_count < CAP) && (!m_valid || ordy != 0);
    acc = (v != 0) && exp_rdy;
    e = ref_encode(cls, f3, alt, rd, rs1, rs2, imm);
    #1 seen_ready = in_ready;
    @(posedge clk);
    if (r != 0) begin
      m_valid = 0; m_instr = 32'd0; m_addr = 0; m_count = 0; m_err = 0; m_pulse = 0;
    end else if (c != 0) begin
      m_valid = 0; m_addr = 0; m_count = 0; m_err = 0; m_pulse = 0;
    end else begin
      m_pulse = acc && !e[32];
      if (m_pulse) m_err = 1;
      if (acc && e[32]) begin
        m_instr = e[31:0]; m_addr = m_count % CAP; m_valid = 1; m_count++;
      end else if (ordy != 0) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int ordy);
    tick(0, 0, 0, 0, 0, 0, 0, 32'd0, ordy, 0, 0);
  endtask

  task automatic do_clr();
    tick(0, 0, 0, 0, 0, 0, 0, 32'd0, 1, 1, 0);
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 0, 0, 0, 32'd0, 1, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 32'd0, 1, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_addr !== '0 || count !== '0 ||
        full !== 1'b0 || err !== 1'b0 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: valid=%b instr=%h addr=%0d count=%0d full=%b err=%b pulse=%b, required all 0",
               out_valid, out_instr, out_addr, count, full, err, err_pulse);
    end
    idle(1);
    checks++;
    if (seen_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b required 1", seen_ready);
    end
  endtask

  task automatic test_known_vectors();
    logic [31:0] req [4];
    req[0] = 32'h002081B3; req[1] = 32'h407302B3; req[2] = 32'hFE208CE3; req[3] = 32'h001000EF;
    do_clr();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: tick(1, 0, 0, 0, 3, 1, 2, 32'd0, 1, 0, 0);
        1: tick(1, 0, 0, 1, 5, 6, 7, 32'd0, 1, 0, 0);
        2: tick(1, 4, 0, 0, 9, 1, 2, 32'hFFFFFFF8, 1, 0, 0);
        default: tick(1, 8, 0, 0, 1, 5, 6, 32'h00000800, 1, 0, 0);
      endcase
      checks++;
      if (out_valid !== 1'b1 || out_instr !== req[i] || out_addr !== D'(i) || count !== (D+1)'(i + 1)) begin
        errors++;
        $display("FAIL vector_%0d: valid=%b instr=%h addr=%0d count=%0d, required 1 %h %0d %0d",
                 i, out_valid, out_instr, out_addr, count, req[i], i, i + 1);
      end
    end
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b required 1", full); end
    tick(1, 0, 0, 0, 3, 1, 2, 32'd0, 1, 0, 0);
    checks++;
    if (seen_ready !== 1'b0 || count !== 3'd4 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_blocks: in_ready=%b count=%0d valid=%b, required 0 4 0", seen_ready, count, out_valid);
    end
    do_clr();
    checks++;
    if (count !== '0 || full !== 1'b0 || err !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_state: count=%0d full=%b err=%b valid=%b, required 0 0 0 0", count, full, err, out_valid);
    end
    tick(1, 6, 0, 0, 4, 0, 0, 32'hABCDE000, 1, 0, 0);
    checks++;
    if (out_addr !== '0 || out_instr !== 32'hABCDE237) begin
      errors++; $display("FAIL after_clr_addr: addr=%0d instr=%h, required 0 abcde237", out_addr, out_instr);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    do_clr();
    tick(1, 1, 0, 0, 1, 2, 0, 32'd5, 0, 0, 0);
    held = m_instr;
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 3, 1, 2, 32'd0, 0, 0, 0);
      checks++;
      if (seen_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== held || count !== 3'd1) begin
        errors++;
        $display("FAIL stall_%0d: in_ready=%b valid=%b instr=%h count=%0d, required 0 1 %h 1",
                 i, seen_ready, out_valid, out_instr, count, held);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1, 2, 2, 0, i + 1, 3, 0, 32'(i * 4), 1, 0, 0);
      checks++;
      if (seen_ready !== 1'b1 || out_valid !== 1'b1 || out_addr !== D'(i + 1) || out_instr !== m_instr) begin
        errors++;
        $display("FAIL stream_%0d: in_ready=%b valid=%b addr=%0d instr=%h, required 1 1 %0d %h",
                 i, seen_ready, out_valid, out_addr, out_instr, i + 1, m_instr);
      end
    end
  endtask

  task automatic test_illegal();
    do_clr();
    tick(1, 4, 2, 0, 0, 1, 2, 32'd8, 1, 0, 0);
    checks++;
    if (err !== 1'b1 || err_pulse !== 1'b1 || out_valid !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL illegal_branch: err=%b pulse=%b valid=%b count=%0d, required 1 1 0 0", err, err_pulse, out_valid, count);
    end
    idle(1);
    checks++;
    if (err !== 1'b1 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL err_sticky: err=%b pulse=%b, required 1 0", err, err_pulse);
    end
    tick(1, 0, 1, 1, 1, 1, 1, 32'd0, 1, 0, 0);
    checks++;
    if (err_pulse !== 1'b1 || count !== '0) begin
      errors++; $display("FAIL illegal_r_alt: pulse=%b count=%0d, required 1 0", err_pulse, count);
    end
    tick(1, 12, 0, 0, 1, 1, 1, 32'd0, 1, 0, 0);
    checks++;
    if (err_pulse !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL illegal_class: pulse=%b valid=%b, required 1 0", err_pulse, out_valid);
    end
    tick(1, 1, 0, 0, 0, 0, 0, 32'd2048, 1, 0, 0);
    checks++;
`ifdef RVENC_IMM_CHECK_EN
    if (err_pulse !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL addi_2048: pulse=%b valid=%b, required 1 0", err_pulse, out_valid);
    end
`else
    if (out_valid !== 1'b1 || out_instr !== 32'h80000013 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL addi_2048: valid=%b instr=%h pulse=%b, required 1 80000013 0", out_valid, out_instr, err_pulse);
    end
`endif
  endtask

  task automatic test_clr_and_rst();
    do_clr();
    tick(1, 0, 0, 0, 3, 1, 2, 32'd0, 1, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL clr_wins: valid=%b count=%0d, required 0 0", out_valid, count);
    end
    tick(1, 0, 0, 0, 3, 1, 2, 32'd0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'd0 || count !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_midstream: valid=%b instr=%h count=%0d err=%b, required 0 0 0 0", out_valid, out_instr, count, err);
    end
  endtask

  task automatic test_random();
    int cls, v, ordy, c, r;
    logic [31:0] imm;
    for (int n = 0; n < 600; n++) begin
      cls  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      v    = ($urandom_range(0, 9) < 7) ? 1 : 0;
      ordy = ($urandom_range(0, 9) < 7) ? 1 : 0;
      c    = ($urandom_range(0, 99) < ((m_count == CAP) ? 30 : 3)) ? 1 : 0;
      r    = ($urandom_range(0, 199) == 0) ? 1 : 0;
      case ($urandom_range(0, 2))
        0: imm = 32'($signed(int'($urandom_range(0, 127)) - 64));
        1: imm = $urandom;
        default: imm = $urandom & 32'hFFFFFFFE;
      endcase
      tick(v, cls, int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 1 : 0,
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           imm, ordy, c, r);
      checks++;
      if (seen_ready !== exp_rdy || out_valid !== m_valid || count !== (D+1)'(m_count) ||
          full !== (m_count == CAP) || err !== m_err || err_pulse !== m_pulse ||
          (m_valid && (out_instr !== m_instr || out_addr !== D'(m_addr)))) begin
        errors++;
        $display("FAIL random_%0d: rdy=%b valid=%b count=%0d err=%b pulse=%b instr=%h addr=%0d, required %b %b %0d %b %b %h %0d",
                 n, seen_ready, out_valid, count, err, err_pulse, out_instr, out_addr,
                 exp_rdy, m_valid, m_count, m_err, m_pulse, m_instr, m_addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_illegal();
    test_clr_and_rst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_stream_encoder.md
# instr_stream_encoder

Synchronous RV32I instruction encoder: the inverse of the core's instruction decoder. Accepts one decoded instruction description per handshake (class, funct3, alt bit, register indices, immediate) and emits the packed 32-bit instruction word with a sequential word address for the instruction-memory loader and self-test harness. Adds input/output valid/ready flow control, an address/fill counter, a flush, and sticky error reporting for illegal field combinations.

## Interface
- DEPTH_LOG2, 8, log2 of instruction-memory depth in words; also sets width of out_addr

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- clr  in  1  synchronous flush: pointer, count, err, out_valid to 0
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_class  in  4  0 R, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JALR, 6 LUI, 7 AUIPC, 8 JAL; 9-15 illegal
- in_funct3  in  3  funct3 field
- in_alt  in  1  selects funct7=0100000 (SUB/SRA/SRAI)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  immediate as signed byte offset/value (U-type: full 32-bit value)
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_instr  out  32  encoded instruction
- out_addr  out  DEPTH_LOG2  word index of out_instr
- count  out  DEPTH_LOG2+1  number of legal words accepted since reset/clr
- full  out  1  count == 2**DEPTH_LOG2
- err  out  1  sticky; set by any illegal request
- err_pulse  out  1  one-cycle pulse the cycle after an illegal request is accepted

## Operation
- in_ready = !full && (!out_valid || out_ready).
- Legal accepted request: register encoded word into out_instr, out_addr = current pointer, out_valid=1; pointer and count +1.
- Illegal accepted request: consumed, not emitted; out_valid unaffected except normal drain; err=1, err_pulse=1; pointer/count unchanged.
- Opcodes: R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JALR 1100111, LUI 0110111, AUIPC 0010111, JAL 1101111.
- Legality: R all funct3, alt only with 000/101. OP-IMM all funct3, alt only with 101. LOAD funct3 in {0,1,2,4,5}. STORE {0,1,2}. BRANCH {0,1,4,5,6,7}. JALR/LUI/AUIPC/JAL: funct3 ignored (JALR encodes 000), alt ignored. Class 9-15 illegal.
- Immediate packing: I imm[11:0] into [31:20]; OP-IMM funct3 001/101: [24:20]=imm[4:0], [31:25]=alt?0100000:0. S: imm[11:5]->[31:25], imm[4:0]->[11:7]. B: imm[12|10:5] ->[31|30:25], imm[4:1|11]->[11:8|7]. U: imm[31:12]->[31:12]. J: imm[20|10:1|11|19:12]->[31|30:21|20|19:12].
- Unused register fields encoded as 0 (rs2 for I/U/J, rd for S/B, rs1 for U/J).
- full: in_ready=0 until clr or rst; pending out word still drains.
- clr and accept same cycle: clr wins, request dropped, out_valid=0.

## Timing
- Reset values: out_valid 0, out_instr 0, out_addr 0, count 0, full 0, err 0, err_pulse 0; in_ready 1 the cycle after reset deasserts.
- Latency 1 cycle accept-to-out_valid; throughput 1 word/cycle with out_ready held high.
- out_instr/out_addr stable while out_valid && !out_ready.
- Pointer wraps never: count saturates at full; out_addr is pointer modulo 2**DEPTH_LOG2.
- rst asserted mid-stream: pending output discarded, next cycle all reset values.

## Configuration
- RVENC_IMM_CHECK_EN defined: immediate range/alignment check; illegal if I/S outside -2048..2047, shift imm outside 0..31, B outside -4096..4094 or odd, J outside -1048576..1048574 or odd, U with imm[11:0] != 0.
- Undefined: no check; out-of-range immediates silently truncated to field bits, bit 0 of B/J dropped.

## Test plan
- add x3,x1,x2 (class 0, f3 0, alt 0) -> out_instr 0x002081B3, out_addr 0, count 1.
- sub x5,x6,x7 (alt 1) next -> 0x407302B3 at out_addr 1.
- beq x1,x2,imm 0xFFFFFFF8 -> 0xFE208CE3; jal x1,imm 0x800 -> 0x001000EF.
- out_ready low 3 cycles with out_valid high -> out_instr constant, in_ready 0; back-to-back stream with out_ready high -> one word/cycle.
- class 4 funct3 2 -> err=1, err_pulse one cycle, no out_valid, count unchanged; with RVENC_IMM_CHECK_EN, addi imm 2048 -> err=1; without, emits 0x80000013 for rd/rs1 x0.
- DEPTH_LOG2=2: four legal accepts -> full=1, count 4, in_ready 0; clr -> count 0, full 0, err 0, next word out_addr 0.
